fcore_pipelined_logic_unit: RTL

Parametrised, pipelined bitwise/shift execution unit for the fCore datapath. It is the successor to the single-cycle logic unit. It adds:
- configurable data and user widths,
- a configurable pipeline depth,
- shift and bit-select operations,
- full valid/ready backpressure on the result stream,
- an illegal-opcode flag.

It sits between the operand fetch stage and the register-file writeback arbiter.

---
 rtl/fcore_pipelined_logic_unit_if.sv | 25 ++
 rtl/fcore_pipelined_logic_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fcore_pipelined_logic_unit_if.sv
// Valid/ready stream bundle used on every port of the fCore logic unit.
// The slave side drives ready; the master side drives valid, data and user.
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;

  modport master (
    output valid,
    output data,
    output user,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  user,
    output ready
  );
endinterface

// File: rtl/fcore_pipelined_logic_unit.sv
// Pipelined bitwise/shift execution unit for the fCore datapath.
// Stage 1 decodes and computes; later stages only delay {valid, data, user}.
module fcore_pipelined_logic_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 4,
  parameter int PIPELINE_DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset,
  axi_stream.slave operand_a,
  axi_stream.slave operand_b,
  axi_stream.slave operand_c,
  axi_stream.slave operation,
  axi_stream.master result,
  output logic     illegal_opcode
);

  if (PIPELINE_DEPTH < 1 || PIPELINE_DEPTH > 4) begin : g_bad_depth
    $error("PIPELINE_DEPTH must be in 1..4");
  end

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int LAST = PIPELINE_DEPTH - 1;

  typedef logic [OPCODE_WIDTH-1:0] op_t;

  localparam op_t OP_AND = op_t'(0);
  localparam op_t OP_OR  = op_t'(1);
  localparam op_t OP_NOT = op_t'(2);
  localparam op_t OP_SHL = op_t'(3);
  localparam op_t OP_SHR = op_t'(4);
  localparam op_t OP_SRA = op_t'(5);
  localparam op_t OP_XOR = op_t'(6);
  localparam op_t OP_SEL = op_t'(7);

  logic [PIPELINE_DEPTH-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]     data_q [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0]     data_d [PIPELINE_DEPTH];
  logic [USER_WIDTH-1:0]     user_q [PIPELINE_DEPTH];
  logic [USER_WIDTH-1:0]     user_d [PIPELINE_DEPTH];
  logic                      ill_q, ill_d;

  logic                         stall;
  logic                         issue_ready;
  logic                         accept;
  logic                         legal;
  logic [DATA_WIDTH-1:0]        res;
  logic [DATA_WIDTH-1:0]        a, b, c;
  logic signed [DATA_WIDTH-1:0] a_s;
  logic [SHW-1:0]               sh;
  op_t                          opc;

  logic unused_ok;
  assign unused_ok = ^{operand_b.valid, operand_c.valid,
                       operation.valid, operand_b.user,
                       operand_c.user, operation.user};

  // Shift amount uses only the low log2(width) bits of b.
  always_comb begin
    a     = operand_a.data;
    b     = operand_b.data;
    c     = operand_c.data;
    a_s   = operand_a.data;
    sh    = operand_b.data[SHW-1:0];
    opc   = operation.data;
    legal = 1'b1;
    res   = '0;
    unique case (1'b1)
      (opc == OP_AND): res = a & b;
      (opc == OP_OR):  res = a | b;
      (opc == OP_NOT): res = ~a;
      (opc == OP_SHL): res = a << sh;
      (opc == OP_SHR): res = a >> sh;
      (opc == OP_SRA): res = a_s >>> sh;
      (opc == OP_XOR): res = a ^ b;
      (opc == OP_SEL): res = (a & c) | (b & ~c);
      default:         legal = 1'b0;
    endcase
  end

  always_comb begin
    stall       = vld_q[LAST] && !result.ready;
    issue_ready = !reset && !stall;
    accept      = operand_a.valid && issue_ready;
    vld_d       = vld_q;
    data_d      = data_q;
    user_d      = user_q;
    // The whole pipe moves together; no bubble collapsing.
    if (!stall) begin
      vld_d[0]  = accept && legal;
      data_d[0] = res;
      user_d[0] = operand_a.user;
      for (int i = 1; i < PIPELINE_DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
        user_d[i] = user_q[i-1];
      end
    end
    ill_d = accept && !legal;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      ill_q <= 1'b0;
      for (int i = 0; i < PIPELINE_DEPTH; i++) begin
        data_q[i] <= '0;
        user_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      ill_q  <= ill_d;
      data_q <= data_d;
      user_q <= user_d;
    end
  end

  assign operand_a.ready = issue_ready;
  assign operand_b.ready = issue_ready;
  assign operand_c.ready = issue_ready;
  assign operation.ready = issue_ready;

  assign result.valid = vld_q[LAST];
  assign result.data  = vld_q[LAST] ? data_q[LAST] : '0;
  assign result.user  = vld_q[LAST] ? user_q[LAST] : '0;

  assign illegal_opcode = ill_q;

endmodule
